polar_encoder: RTL and testbench
================================

# polar_encoder

Serial-in / serial-out polar encoder for the transmit side of the polar decoding datapath. It accepts N message bits one per handshake, with a per-bit frozen flag that forces frozen positions to 0. It applies the polar transform x = u·F^⊗n (natural order, no bit reversal) with one butterfly stage per cycle, then streams the N codeword bits out under ready/valid backpressure. Supported lengths are N = 128, 256 and 512; the block produces codewords for the decoder test path.

## Interface
Parameters:
- N_MAX, 512, capacity of the internal codeword register; fixed at 512.
- LOG_N_MAX, 9, log2(N_MAX).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset; **synchronous, active-low**.
- start  input  1  one-cycle pulse that begins a frame; sampled only in IDLE.
- n_sel  input  2  length select, sampled with start: 0 → 128, 1 → 256, 2 → 512, 3 → reserved and treated as 512.
- in_valid  input  1  in_bit/in_frozen valid.
- in_ready  output  1  block accepts an input bit; high only in LOAD.
- in_bit  input  1  message bit u[i].
- in_frozen  input  1  1 = position i is frozen; the stored bit is then 0 regardless of in_bit.
- out_valid  output  1  out_bit valid; high only in OUT.
- out_ready  input  1  downstream accepts out_bit.
- out_bit  output  1  codeword bit x[i], emitted in index order 0..N-1.
- out_last  output  1  high together with out_valid on index N-1.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last output transfer.

## Operation
- Storage and counters:
  - x[0:N_MAX-1] register array.
  - cnt (9 bits) serves as the input index, the stage index and the output index in turn.
  - n_log latch holds 7, 8 or 9.
- State machine (one-hot or encoded):
  - IDLE → LOAD on start. Latch n_log, cnt = 0, clear x to 0.
  - LOAD: on each in_valid & in_ready, x[cnt] = in_bit & ~in_frozen and cnt increments. The accept at cnt = N-1 moves to ENC with cnt = 0.
  - ENC: one stage s = cnt per cycle. For every i < N with bit s of i clear, x[i] ← x[i] ^ x[i + 2^s]; entries with bit s set are unchanged. At s = n_log-1, move to OUT with cnt = 0.
  - OUT: out_bit = x[cnt]. Each out_valid & out_ready increments cnt. The transfer at cnt = N-1 moves to DONE.
  - DONE: done = 1 for exactly one cycle, then IDLE.
- Entries with index ≥ N stay 0 and are never output.
- start is ignored outside IDLE. in_valid is ignored outside LOAD. out_ready is ignored outside OUT.
- Equivalent closed form for the bench model: x[i] = XOR of u[j] over all j < N with (j & i) == i.

## Timing
- Reset (rst_n low at an edge) clears the following, from any state including mid-LOAD, ENC or OUT:
  - state = IDLE, cnt = 0, x = 0, n_log = 9.
  - in_ready, out_valid, out_bit, out_last, busy and done all 0.
  - The partial frame is discarded and no done pulse is produced.
- start sampled at edge t: busy and in_ready are 1 from cycle t+1.
- Input accepts need not be consecutive; in_valid gaps simply stall LOAD.
- Let edge c be the Nth input accept:
  - in_ready drops in cycle c+1.
  - ENC occupies cycles c+1 .. c+n_log.
  - out_valid rises in cycle c+n_log+1 with out_bit = x[0].
- Output follows ready/valid rules:
  - out_bit and out_last hold stable while out_valid & ~out_ready.
  - With out_ready held at 1, one bit transfers per cycle.
- Let the final transfer occur at edge e:
  - done = 1 and busy = 1 in cycle e+1.
  - IDLE in cycle e+2. A start in cycle e+2 is accepted.
- Minimum frame time with no stalls: 1 + N + n_log + N + 1 cycles.

## Test plan
- Reset and idle: hold rst_n low, then release. Required: all outputs 0; in_ready stays 0 until start.
- Unit vectors, N=128: only u[0]=1 → x[0]=1 and x[1..127]=0. Only u[127]=1 → all 128 bits are 1. out_last is high only on index 127. out_valid rises exactly 8 cycles after the last accept.
- Frozen override, N=256: in_bit=1 on every index, with in_frozen=1 for indices 0..254. Required result is the same as u[255]=1 alone: all 256 bits are 1. With all positions frozen, all bits are 0.
- Random N=512 and n_sel=3: 20 random frames with random in_valid gaps and random out_ready stalls. Compare against the closed-form model. out_bit must stay stable during each stall, and exactly one done pulse is required per frame.
- Reset mid-operation: assert rst_n low during ENC stage 3, then run a fresh N=128 frame with u[0]=1. Required: the output is correct and no stale bits from the aborted frame appear.
- Back-to-back frames: pulse start in the first IDLE cycle after done, and also pulse start during OUT. The start during OUT must be ignored; the start in IDLE begins LOAD on the next cycle.

Source files
------------

// File: rtl/polar_encoder.sv
// Serial-in / serial-out polar encoder, x = u * F^(xn), natural order.
// One butterfly stage per cycle over an N_MAX-wide codeword register.
module polar_encoder #(
  parameter int N_MAX     = 512,
  parameter int LOG_N_MAX = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] n_sel,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_frozen,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_bit,
  output logic       out_last,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ENC,
    S_OUT,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [LOG_N_MAX-1:0] cnt_q, cnt_d;
  logic [3:0]           nlog_q, nlog_d;
  logic [N_MAX-1:0]     x_q, x_d;
  logic [N_MAX-1:0]     enc_x;
  logic [LOG_N_MAX:0]   n_len;
  logic [LOG_N_MAX-1:0] last_idx;
  logic [LOG_N_MAX-1:0] last_stg;
  logic [LOG_N_MAX-1:0] stage_bit;
  logic [LOG_N_MAX-1:0] idx;

  assign n_len    = (LOG_N_MAX+1)'(1) << nlog_q;
  assign last_idx = LOG_N_MAX'(n_len - 1'b1);
  assign last_stg = LOG_N_MAX'(nlog_q - 4'd1);
  assign stage_bit = LOG_N_MAX'(1) << cnt_q;

  // Butterfly for stage cnt_q: lower partner absorbs the upper one.
  always_comb begin
    enc_x = x_q;
    idx   = '0;
    for (int i = 0; i < N_MAX; i++) begin
      idx = LOG_N_MAX'(i);
      if ((idx & stage_bit) == '0)
        enc_x[i] = x_q[i] ^ x_q[idx | stage_bit];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nlog_d  = nlog_q;
    x_d     = x_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          x_d     = '0;
          unique case (n_sel)
            2'd0:    nlog_d = 4'd7;
            2'd1:    nlog_d = 4'd8;
            default: nlog_d = 4'd9;
          endcase
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          x_d[cnt_q] = in_bit & ~in_frozen;
          if (cnt_q == last_idx) begin
            state_d = S_ENC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_ENC: begin
        x_d = enc_x;
        if (cnt_q == last_stg) begin
          state_d = S_OUT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (cnt_q == last_idx) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      nlog_q  <= 4'd9;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nlog_q  <= nlog_d;
      x_q     <= x_d;
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_OUT);
  assign out_bit   = out_valid & x_q[cnt_q];
  assign out_last  = out_valid & (cnt_q == last_idx);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_polar_encoder.sv
// Directed + random bench for polar_encoder.
// Expected codeword bits come from the closed-form subset-XOR model.
module tb_polar_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] n_sel;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       in_frozen;
  logic       out_valid;
  logic       out_ready;
  logic       out_bit;
  logic       out_last;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit ua[512];
  bit fa[512];
  bit q[$];

  polar_encoder #(.N_MAX(512), .LOG_N_MAX(9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_sel(n_sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_bit(in_bit), .in_frozen(in_frozen),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nlog_of(input int nsel);
    return (nsel == 0) ? 7 : (nsel == 1) ? 8 : 9;
  endfunction

  task automatic clear_u();
    for (int i = 0; i < 512; i++) begin
      ua[i] = 1'b0;
      fa[i] = 1'b0;
    end
  endtask

  task automatic begin_frame(input int nsel);
    start = 1'b1;
    n_sel = 2'(nsel);
    @(negedge clk);
    start = 1'b0;
    chk("in_ready_after_start", in_ready, 1);
    chk("busy_after_start", busy, 1);
  endtask

  task automatic load_bits(input int n, input int gap_pct);
    int idx;
    int tmo;
    bit acc;
    idx = 0;
    tmo = 0;
    while (idx < n && tmo < 4 * n + 100) begin
      in_valid  = ($urandom_range(99) >= gap_pct);
      in_bit    = ua[idx];
      in_frozen = fa[idx];
      acc = in_valid && in_ready;
      @(negedge clk);
      tmo++;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    if (idx < n) chk("load_timeout", idx, n);
  endtask

  task automatic run_frame(input int nsel, input int gap_pct,
                           input int stall_pct, input bit start_in_out);
    int n;
    int nl;
    int k;
    int idx;
    int tmo;
    int dc0;
    bit e;
    bit prev_stall;
    logic pb;
    logic pl;
    nl = nlog_of(nsel);
    n = 1 << nl;
    q.delete();
    for (int i = 0; i < n; i++) begin
      e = 1'b0;
      for (int j = 0; j < n; j++)
        if ((j & i) == i) e ^= ua[j] & ~fa[j];
      q.push_back(e);
    end
    dc0 = done_cnt;
    begin_frame(nsel);
    load_bits(n, gap_pct);
    k = 1;
    chk("in_ready_drop", in_ready, 0);
    while (!out_valid && k < 64) begin
      @(negedge clk);
      k++;
    end
    chk("out_valid_latency", k, nl + 1);
    idx = 0;
    tmo = 0;
    prev_stall = 1'b0;
    pb = 1'b0;
    pl = 1'b0;
    while (idx < n && tmo < 4 * n + 100) begin
      if (prev_stall) begin
        chk("stall_bit", out_bit, pb);
        chk("stall_last", out_last, pl);
      end
      chk("out_valid_hold", out_valid, 1);
      start = start_in_out && (idx == 5);
      out_ready = ($urandom_range(99) >= stall_pct);
      if (out_ready) begin
        e = q.pop_front();
        chk($sformatf("out_bit[%0d]", idx), out_bit, e);
        chk($sformatf("out_last[%0d]", idx), out_last, (idx == n - 1));
        idx++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = 1'b1;
        pb = out_bit;
        pl = out_last;
      end
      @(negedge clk);
      tmo++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    if (idx < n) chk("out_timeout", idx, n);
    chk("done_pulse", done, 1);
    chk("busy_in_done", busy, 1);
    chk("out_valid_in_done", out_valid, 0);
    @(negedge clk);
    chk("done_low", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_ready, 0);
    chk("done_count", done_cnt - dc0, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_bit"}, out_bit, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    int dc0;
    rst_n = 1'b0;
    start = 1'b0;
    n_sel = 2'd0;
    in_valid = 1'b0;
    in_bit = 1'b0;
    in_frozen = 1'b0;
    out_ready = 1'b0;

    // Reset and idle, with input/output handshakes ignored in IDLE.
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("idle");
    in_valid = 1'b0;
    out_ready = 1'b0;

    // Unit vectors, N=128.
    clear_u();
    ua[0] = 1'b1;
    run_frame(0, 0, 0, 1'b0);
    clear_u();
    ua[127] = 1'b1;
    run_frame(0, 20, 20, 1'b0);

    // Frozen override, N=256.
    for (int i = 0; i < 512; i++) begin
      ua[i] = 1'b1;
      fa[i] = (i < 255);
    end
    run_frame(1, 10, 10, 1'b0);
    for (int i = 0; i < 512; i++) begin
      ua[i] = 1'b1;
      fa[i] = 1'b1;
    end
    run_frame(1, 0, 0, 1'b0);

    // Back-to-back: start during OUT ignored, start in first IDLE cycle taken.
    for (int i = 0; i < 512; i++) begin
      ua[i] = 1'($urandom_range(1));
      fa[i] = 1'($urandom_range(1));
    end
    run_frame(0, 0, 30, 1'b1);
    for (int i = 0; i < 512; i++) ua[i] = 1'($urandom_range(1));
    run_frame(0, 0, 0, 1'b0);

    // Reset during ENC stage 3, then a fresh frame.
    for (int i = 0; i < 512; i++) begin
      ua[i] = 1'($urandom_range(1));
      fa[i] = 1'b0;
    end
    dc0 = done_cnt;
    begin_frame(0);
    load_bits(128, 0);
    repeat (3) @(negedge clk);
    chk("enc_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("postreset");
    chk("abort_no_done", done_cnt - dc0, 0);
    clear_u();
    ua[0] = 1'b1;
    run_frame(0, 0, 0, 1'b0);

    // Random N=512 frames via n_sel=2 and the reserved n_sel=3.
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < 512; i++) begin
        ua[i] = 1'($urandom_range(1));
        fa[i] = ($urandom_range(3) == 0);
      end
      run_frame((f % 2 == 0) ? 3 : 2, 25, 25, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
